// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Used by the hazard top and the HI/LO occupancy tracker.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   localparam int         MULDIV_LAT_DEF = 4;
   localparam logic [1:0] JUMP_NONE      = 2'b00;

   function automatic logic src_hit(
      input logic       uses,
      input logic [4:0] src,
      input logic [4:0] dst
   );
      return uses & (src == dst);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_muldiv_occupancy.sv
// Tracks how long a mult/div that left EX keeps HI/LO occupied.
// Holds while the pipe is frozen; a fresh start reloads the count.
module muldiv_occupancy
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int MULDIV_LAT = MULDIV_LAT_DEF
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Freeze,
   input  logic Start,
   output logic Busy
);

   localparam int CW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(MULDIV_LAT - 1);

   md_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // State and remaining-cycle register
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: enter on start, count down while the pipe moves
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!Freeze) begin
         unique case (state_q)
            RUN: begin
               if (Start) begin
                  state_d = MD_BUSY;
                  cnt_d   = RELOAD;
               end
            end
            MD_BUSY: begin
               if (Start) begin
                  cnt_d = RELOAD;
               end else if (cnt_q == '0) begin
                  state_d = RUN;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: begin
               state_d = RUN;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign Busy = (state_q == MD_BUSY);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Drives pipeline register Ld/Clr, PC enable and a stall counter.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int MULDIV_LAT = MULDIV_LAT_DEF,
   parameter int CNT_W      = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [4:0]       ID_Rs,
   input  logic [4:0]       ID_Rt,
   input  logic             ID_UsesRs,
   input  logic             ID_UsesRt,
   input  logic             ID_ReadsHiLo,
   input  logic             ID_IsMulDiv,
   input  logic             EX_MemRead,
   input  logic             EX_RegWrite,
   input  logic [4:0]       EX_RegDstData,
   input  logic             EX_MulDivStart,
   input  logic             MEM_Branch,
   input  logic             MEM_Zero,
   input  logic [1:0]       MEM_Jump,
   input  logic             MemBusy,
   output logic             PCWrite,
   output logic             IF_ID_Ld,
   output logic             IF_ID_Clr,
   output logic             ID_EX_Ld,
   output logic             ID_EX_Clr,
   output logic             EX_MEM_Ld,
   output logic             EX_MEM_Clr,
   output logic             MEM_WB_Ld,
   output logic             MEM_WB_Clr,
   output logic             PCSrcTaken,
   output logic             MulDivBusy,
   output logic [CNT_W-1:0] StallCount
);

   logic md_busy;
   logic taken;
   logic load_use;
   logic hilo_stall;
   logic count_en;
   logic [CNT_W-1:0] cnt_q;

   muldiv_occupancy #(
      .MULDIV_LAT (MULDIV_LAT)
   ) u_md (
      .Clk    (Clk),
      .Reset  (Reset),
      .Freeze (MemBusy),
      .Start  (EX_MulDivStart),
      .Busy   (md_busy)
   );

   assign taken = (MEM_Branch & MEM_Zero) | (MEM_Jump != JUMP_NONE);

   assign load_use = EX_MemRead & EX_RegWrite
                   & (EX_RegDstData != 5'd0)
                   & (src_hit(ID_UsesRs, ID_Rs, EX_RegDstData)
                    | src_hit(ID_UsesRt, ID_Rt, EX_RegDstData));

   assign hilo_stall = md_busy & (ID_ReadsHiLo | ID_IsMulDiv);

   assign MulDivBusy = md_busy & ~Reset;

   assign count_en = ~Reset
                   & (MemBusy | (~taken & (load_use | hilo_stall)));

   // Pick the register controls by hazard priority
   always_comb begin
      PCWrite    = 1'b1;
      IF_ID_Ld   = 1'b1;
      IF_ID_Clr  = 1'b0;
      ID_EX_Ld   = 1'b1;
      ID_EX_Clr  = 1'b0;
      EX_MEM_Ld  = 1'b1;
      EX_MEM_Clr = 1'b0;
      MEM_WB_Ld  = 1'b1;
      MEM_WB_Clr = 1'b0;
      PCSrcTaken = 1'b0;
      priority case (1'b1)
         Reset: begin
            PCWrite    = 1'b0;
            IF_ID_Ld   = 1'b0;
            ID_EX_Ld   = 1'b0;
            EX_MEM_Ld  = 1'b0;
            MEM_WB_Ld  = 1'b0;
            IF_ID_Clr  = 1'b1;
            ID_EX_Clr  = 1'b1;
            EX_MEM_Clr = 1'b1;
            MEM_WB_Clr = 1'b1;
         end
         MemBusy: begin
            PCWrite   = 1'b0;
            IF_ID_Ld  = 1'b0;
            ID_EX_Ld  = 1'b0;
            EX_MEM_Ld = 1'b0;
            MEM_WB_Ld = 1'b0;
         end
         taken: begin
            PCSrcTaken = 1'b1;
            IF_ID_Clr  = 1'b1;
            ID_EX_Clr  = 1'b1;
            EX_MEM_Clr = 1'b1;
         end
         (load_use | hilo_stall): begin
            PCWrite   = 1'b0;
            IF_ID_Ld  = 1'b0;
            ID_EX_Clr = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Saturating count of stall and freeze cycles
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt_q <= '0;
      end else if (count_en && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign StallCount = cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the Ld/Clr pair of every pipeline register (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC write enable.
- Detects load-use hazards, tracks multi-cycle mult/div occupancy of HI/LO, flushes on branch/jump resolved in MEM, and freezes the pipe on memory busy.
- Keeps a saturating stall-cycle counter for performance checks.

Parameters:
- MULDIV_LAT, 4, cycles a mult/div occupies HI/LO after it leaves EX (≥1).
- CNT_W, 16, width of stall counter.

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous active-high reset
- ID_Rs  in  5  rs field of instruction in ID
- ID_Rt  in  5  rt field of instruction in ID
- ID_UsesRs  in  1  ID instruction reads rs
- ID_UsesRt  in  1  ID instruction reads rt
- ID_ReadsHiLo  in  1  ID instruction is mfhi/mflo/madd/msub (HI/LO reader)
- ID_IsMulDiv  in  1  ID instruction is mult/multu/div/divu
- EX_MemRead  in  1  load in EX
- EX_RegWrite  in  1  EX writes the register file
- EX_RegDstData  in  5  EX destination register
- EX_MulDivStart  in  1  mult/div leaving EX this cycle
- MEM_Branch  in  1  branch in MEM
- MEM_Zero  in  1  branch condition true in MEM
- MEM_Jump  in  2  jump type in MEM (0 = none)
- MemBusy  in  1  data memory not ready; freeze whole pipe
- PCWrite  out  1  PC load enable
- IF_ID_Ld, IF_ID_Clr  out  1 each  IF/ID register control
- ID_EX_Ld, ID_EX_Clr  out  1 each  ID/EX register control
- EX_MEM_Ld, EX_MEM_Clr  out  1 each  EX/MEM register control
- MEM_WB_Ld, MEM_WB_Clr  out  1 each  MEM/WB register control
- PCSrcTaken  out  1  PC must take MEM-stage target this cycle
- MulDivBusy  out  1  HI/LO occupied
- StallCount  out  CNT_W  saturating count of stall/freeze cycles

Behaviour:
- Control outputs are combinational from inputs plus registered FSM state. No added latency: a hazard acts in the cycle it is detected.
- Default (RUN, no hazard): PCWrite = 1, all Ld = 1, all Clr = 0, PCSrcTaken = 0.
- Priority, highest first: Reset > freeze > flush > load-use stall > HI/LO stall.
- Reset cycle:
  - All Ld = 0, all Clr = 1, PCWrite = 0, PCSrcTaken = 0.
  - FSM → RUN, counter → 0, StallCount → 0, MulDivBusy = 0.
- Freeze (MemBusy = 1):
  - PCWrite = 0, all Ld = 0, all Clr = 0; state, counter and StallCount++ only.
  - A pending branch/jump stays in EX/MEM and is acted on the first cycle MemBusy = 0.
- Flush: taken = (MEM_Branch & MEM_Zero) | (MEM_Jump != 0).
  - PCSrcTaken = 1, PCWrite = 1.
  - IF_ID_Clr = ID_EX_Clr = EX_MEM_Clr = 1; MEM_WB_Ld = 1.
  - Overrides any stall the same cycle. Not counted as a stall.
- Load-use stall: EX_MemRead & EX_RegWrite & EX_RegDstData != 0 & ((ID_UsesRs & ID_Rs == EX_RegDstData) | (ID_UsesRt & ID_Rt == EX_RegDstData)).
  - PCWrite = 0, IF_ID_Ld = 0, ID_EX_Clr = 1 (bubble); EX_MEM and MEM_WB advance.
  - Exactly one cycle; clears naturally once the load leaves EX. StallCount++.
- HI/LO stall: MulDivBusy & (ID_ReadsHiLo | ID_IsMulDiv). Same actions as load-use stall. StallCount++.
- FSM states:
  - RUN: EX_MulDivStart → MD_BUSY, cnt = MULDIV_LAT-1.
  - MD_BUSY: cnt decrements each non-frozen cycle; cnt == 0 → RUN.
  - MulDivBusy = (state == MD_BUSY).
  - EX_MulDivStart while in MD_BUSY cannot occur (blocked by HI/LO stall). If asserted anyway, counter reloads.
  - Flush does not cancel MD_BUSY: the mult/div is already past EX and commits.
- StallCount saturates at all-ones; no wrap.
- Reset mid-stall or mid-MD_BUSY: Reset wins, RUN next cycle.

Decomposition:
- Shared package: FSM state encoding (RUN = 0, MD_BUSY = 1), MULDIV_LAT default, MEM_Jump "none" code (2'b00).
- One sub-module, muldiv_occupancy: FSM + down-counter, outputs MulDivBusy.
- Hazard logic and counter stay in the top.

Test Plan:
- Reset: hold Reset 2 cycles → all Clr = 1, Ld = 0, PCWrite = 0, StallCount = 0; release → all Ld = 1, PCWrite = 1.
- Load-use: EX lw to $8 (EX_MemRead = 1, EX_RegDstData = 8), ID add with Rs = 8 → one cycle PCWrite = 0, IF_ID_Ld = 0, ID_EX_Clr = 1; next cycle normal; StallCount = 1. Repeat with dest = 0 → no stall.
- Mult/div: EX_MulDivStart pulse, MULDIV_LAT = 4, ID mfhi next cycle → stalled exactly 4 cycles, MulDivBusy high 4 cycles, StallCount = 4.
- Flush vs stall: MEM_Branch = 1, MEM_Zero = 1 while a load-use hazard is present → PCSrcTaken = 1, IF_ID/ID_EX/EX_MEM Clr = 1, PCWrite = 1, StallCount unchanged.
- Freeze: MemBusy high 3 cycles during a pending MEM jump (MEM_Jump = 2) → all Ld = 0, no Clr, StallCount += 3; on release, flush occurs in the first cycle.
- Saturation: CNT_W = 4, 20 stall cycles → StallCount = 15 held.
